// File: rtl/dtree_pkg.sv
// Shared types and widths for the sequential decision-tree classifier.
// Node word layout (MSB..LSB): internal | feat_idx | shift | thresh | left | right.
package dtree_pkg;

    localparam int unsigned N_FEAT    = 16;
    localparam int unsigned FEAT_W    = 8;
    localparam int unsigned N_NODES   = 64;
    localparam int unsigned CLASS_W   = 4;
    localparam int unsigned MAX_DEPTH = 15;

    localparam int unsigned NADDR_W  = $clog2(N_NODES);
    localparam int unsigned FIDX_W   = $clog2(N_FEAT);
    localparam int unsigned SHIFT_W  = 3;
    localparam int unsigned FEATS_W  = N_FEAT * FEAT_W;
    localparam int unsigned NODE_W   = 1 + FIDX_W + SHIFT_W + FEAT_W + 2 * NADDR_W;

    typedef struct packed {
        logic               internal;
        logic [FIDX_W-1:0]  feat_idx;
        logic [SHIFT_W-1:0] shift;
        logic [FEAT_W-1:0]  thresh;
        logic [NADDR_W-1:0] left;
        logic [NADDR_W-1:0] right;
    } node_t;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } state_t;

    // Coarse compare: only the top FEAT_W-shift bits of the feature take part.
    function automatic logic node_go_left(input logic [FEAT_W-1:0]  feat,
                                          input logic [SHIFT_W-1:0] shift,
                                          input logic [FEAT_W-1:0]  thresh);
        return (feat >> shift) <= thresh;
    endfunction

endpackage

// File: rtl/dtree_node_mem.sv
// Node table: register file, async-cleared, one write port and one combinational read port.
module dtree_node_mem
    import dtree_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [NADDR_W-1:0] waddr,
    input  logic [NODE_W-1:0]  wdata,
    input  logic [NADDR_W-1:0] raddr,
    output logic [NODE_W-1:0]  rdata_c
);

    logic [NODE_W-1:0] mem [N_NODES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_NODES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/dtree_seq_classifier.sv
// Sequential decision-tree classifier: walks the loadable node table one node per clock.
// Optional DTREE_DEPTH_GUARD_EN aborts walks deeper than MAX_DEPTH with out_err.
module dtree_seq_classifier
    import dtree_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FEATS_W-1:0] in_feat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err,
    input  logic               cfg_we,
    input  logic [NADDR_W-1:0] cfg_addr,
    input  logic [NODE_W-1:0]  cfg_data
);

    state_t               state_q, state_d;
    logic [NADDR_W-1:0]   cur_q, cur_d;
    logic [FEATS_W-1:0]   feat_q, feat_d;
    logic [CLASS_W-1:0]   class_d;
    logic [NODE_W-1:0]    node_word_c;
    node_t                node;
    logic [FEAT_W-1:0]    feat_sel;
    logic                 go_left;
    logic [NADDR_W-1:0]   child_raw;
    logic [NADDR_W-1:0]   child;

`ifdef DTREE_DEPTH_GUARD_EN
    localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH + 1);
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic                 err_d;
`endif

    // Table writes are only honoured while no walk is in flight.
    dtree_node_mem u_node_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (cfg_we && (state_q == IDLE)),
        .waddr   (cfg_addr),
        .wdata   (cfg_data),
        .raddr   (cur_q),
        .rdata_c (node_word_c)
    );

    assign node = node_t'(node_word_c);

    // Out-of-range feature indices fall back to feature 0.
    always_comb begin
        feat_sel = feat_q[0 +: FEAT_W];
        for (int unsigned i = 0; i < N_FEAT; i++) begin
            if (node.feat_idx == FIDX_W'(i)) begin
                feat_sel = feat_q[i * FEAT_W +: FEAT_W];
            end
        end
    end

    assign go_left   = node_go_left(feat_sel, node.shift, node.thresh);
    assign child_raw = go_left ? node.left : node.right;

    generate
        if (N_NODES == (1 << NADDR_W)) begin : g_child_pow2
            assign child = child_raw;
        end else begin : g_child_wrap
            assign child = (child_raw >= NADDR_W'(N_NODES)) ? child_raw - NADDR_W'(N_NODES)
                                                             : child_raw;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        feat_d  = feat_q;
        class_d = out_class;
`ifdef DTREE_DEPTH_GUARD_EN
        depth_d = depth_q;
        err_d   = out_err;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    feat_d  = in_feat;
                    cur_d   = '0;
                    state_d = WALK;
`ifdef DTREE_DEPTH_GUARD_EN
                    depth_d = '0;
`endif
                end
            end
            WALK: begin
                if (!node.internal) begin
                    class_d = node_word_c[CLASS_W-1:0];
                    state_d = DONE;
                end
`ifdef DTREE_DEPTH_GUARD_EN
                else if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                    class_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
                else begin
                    cur_d = child;
`ifdef DTREE_DEPTH_GUARD_EN
                    depth_d = depth_q + DEPTH_W'(1);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef DTREE_DEPTH_GUARD_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            feat_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_class <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            feat_q    <= feat_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            out_class <= class_d;
        end
    end

`ifdef DTREE_DEPTH_GUARD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
            out_err <= 1'b0;
        end else begin
            depth_q <= depth_d;
            out_err <= err_d;
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_dtree_seq_classifier.sv
// Self-checking bench for dtree_seq_classifier: vector table, scoreboard queue and
// hand-written multi-cycle sequences (stall, cfg during walk, cyclic table, reset mid-walk).
module tb_dtree_seq_classifier;
    import dtree_pkg::*;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               in_valid  = 1'b0;
    logic               in_ready;
    logic [FEATS_W-1:0] in_feat   = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [CLASS_W-1:0] out_class;
    logic               out_err;
    logic               cfg_we    = 1'b0;
    logic [NADDR_W-1:0] cfg_addr  = '0;
    logic [NODE_W-1:0]  cfg_data  = '0;

    dtree_seq_classifier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_err   (out_err),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] cls;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] f3;
        logic [3:0] cls;
    } vec_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Node words built directly from the documented field order and widths.
    function automatic logic [27:0] mk_int(input int fidx, input int sh, input int thr,
                                           input int l, input int r);
        return {1'b1, 4'(fidx), 3'(sh), 8'(thr), 6'(l), 6'(r)};
    endfunction

    function automatic logic [27:0] mk_leaf(input int cls);
        return {22'b0, 6'(cls)};
    endfunction

    function automatic logic [FEATS_W-1:0] rand_feat();
        logic [FEATS_W-1:0] f;
        for (int i = 0; i < 16; i++) f[i*8 +: 8] = 8'($urandom);
        return f;
    endfunction

    task automatic push_exp(input int cls, input logic err);
        exp_t e;
        e.cls = 4'(cls);
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic write_node(input int a, input logic [27:0] d);
        cfg_we   = 1'b1;
        cfg_addr = 6'(a);
        cfg_data = d;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic accept(input logic [FEATS_W-1:0] f);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_feat  = f;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // n0 = negedges already elapsed since the accepting edge.
    task automatic collect(input string name, input int lat, input int n0);
        int   n = n0;
        exp_t e;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n, lat);
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_scoreboard: out_valid with no expected result queued", name);
            end else begin
                e = exp_q.pop_front();
                check({name, "_class"}, out_class, e.cls);
                check({name, "_err"}, out_err, e.err);
            end
        end else begin
            exp_q.delete();
        end
        if (out_ready) @(negedge clk);
    endtask

    task automatic load_chain();
        for (int i = 0; i < 4; i++) write_node(i, mk_int(0, 0, 255, i + 1, 63));
        write_node(4, mk_leaf(5));
    endtask

    vec_t             vt[6];
    logic [FEATS_W-1:0] f;
    logic             saw;

    initial begin
        vt[0] = '{8'h40, 4'd7};
        vt[1] = '{8'h80, 4'd9};
        vt[2] = '{8'h7F, 4'd7};
        vt[3] = '{8'hC0, 4'd9};
        vt[4] = '{8'h00, 4'd7};
        vt[5] = '{8'hFF, 4'd9};

        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_class", out_class, 0);
        check("rst_out_err", out_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty table: root is leaf class 0.
        push_exp(0, 1'b0);
        accept(rand_feat());
        collect("empty_table", 1, 0);

        // Three-node tree on feature 3, top two bits compared against 1.
        write_node(0, mk_int(3, 6, 1, 1, 2));
        write_node(1, mk_leaf(7));
        write_node(2, mk_leaf(9));
        foreach (vt[i]) begin
            f = rand_feat();
            f[3*8 +: 8] = vt[i].f3;
            push_exp(int'(vt[i].cls), 1'b0);
            accept(f);
            collect($sformatf("tree3_v%0d", i), 2, 0);
        end

        // Depth-4 chain with the consumer stalled.
        load_chain();
        out_ready = 1'b0;
        push_exp(5, 1'b0);
        accept(rand_feat());
        collect("chain_stall", 5, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_class", out_class, 5);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        push_exp(5, 1'b0);
        accept(rand_feat());
        collect("chain_after_release", 5, 0);

        // Writes during WALK are dropped.
        push_exp(5, 1'b0);
        accept(rand_feat());
        cfg_we   = 1'b1;
        cfg_addr = 6'd4;
        cfg_data = mk_leaf(11);
        @(negedge clk);
        cfg_addr = 6'd1;
        cfg_data = mk_leaf(13);
        @(negedge clk);
        cfg_we   = 1'b0;
        collect("walk_write_dropped", 5, 2);
        push_exp(5, 1'b0);
        accept(rand_feat());
        collect("table_unchanged", 5, 0);

        // Write and accept in the same IDLE cycle: walk sees the new leaf.
        cfg_we   = 1'b1;
        cfg_addr = 6'd4;
        cfg_data = mk_leaf(12);
        push_exp(12, 1'b0);
        accept(rand_feat());
        cfg_we   = 1'b0;
        collect("same_cycle_write", 5, 0);

        // Cyclic table: root points at itself.
        write_node(0, mk_int(0, 0, 0, 0, 0));
`ifdef DTREE_DEPTH_GUARD_EN
        push_exp(0, 1'b1);
        accept(rand_feat());
        collect("guard_abort", int'(MAX_DEPTH) + 1, 0);
        check("guard_err_cleared", out_err, 0);
`else
        accept(rand_feat());
        saw = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        check("cyclic_no_out_valid", saw, 0);
`endif
        rst_n = 1'b0;
        #1;
        check("cyc_rst_in_ready", in_ready, 1);
        check("cyc_rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted mid-walk.
        load_chain();
        accept(rand_feat());
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midwalk_in_ready", in_ready, 1);
        check("midwalk_out_valid", out_valid, 0);
        check("midwalk_out_class", out_class, 0);
        check("midwalk_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            saw = saw | out_valid;
        end
        check("midwalk_no_stray_valid", saw, 0);
        push_exp(0, 1'b0);
        accept(rand_feat());
        collect("post_reset_table_cleared", 1, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
